// File: rtl/bpa_bist_checker_pkg.sv
// rtl/bpa_bist_checker_pkg.sv - shared definitions for the bpa BIST checker
//
// Purpose: FSM state encoding shared by the checker and its testbench.
// Ports  : none (package).
package bpa_bist_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/bpa_golden.sv
// rtl/bpa_golden.sv - combinational reference adder {cout,s} = a + b + cin
//
// Purpose: golden model of the 4-bit binary parallel adder, evaluated at WIDTH+1 bits.
// Ports  : a, b   - WIDTH-bit operands
//          cin    - carry-in
//          sum    - WIDTH+1-bit result, sum[WIDTH] is the carry-out
module bpa_golden #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/bpa_bist_checker.sv
// rtl/bpa_bist_checker.sv - exhaustive sweep and response checker for an external bpa
//
// Purpose: drives every {a,b,c_in} vector into an external adder, samples its response after
//          a settle window and compares it with a golden sum. Mismatches are counted
//          (saturating) and the first failing vector is latched.
// Ports  : clk, rst (sync, active-high), start (one-cycle pulse)
//          dut_a/dut_b/dut_cin  - vector driven to the adder
//          dut_s/dut_cout       - adder response
//          busy, done, pass     - sweep status
//          err_count            - mismatch count
//          first_fail_vld/vec   - first mismatching {a,b,c_in}
module bpa_bist_checker
  import bpa_bist_checker_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SETTLE      = 2,
  parameter int ERR_W       = 10,
  parameter int STOP_ON_ERR = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  output logic               dut_cin,
  input  logic [WIDTH-1:0]   dut_s,
  input  logic               dut_cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic               first_fail_vld,
  output logic [2*WIDTH:0]   first_fail_vec
);

  localparam int VW = 2 * WIDTH + 1;
  // Settle counter only needs to hold SETTLE-1.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e state_q, state_d;

  logic [VW-1:0]    v_q, v_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             ffv_q, ffv_d;
  logic [VW-1:0]    ffvec_q, ffvec_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;

  logic [WIDTH:0]   gold_sum;
  logic             mismatch;
  logic             last_vec;
  logic             stop_now;

  // Reference is fed from the registered drive values so it always matches what the bpa sees.
  bpa_golden #(.WIDTH(WIDTH)) u_golden (
    .a   (a_q),
    .b   (b_q),
    .cin (cin_q),
    .sum (gold_sum)
  );

  assign mismatch = ({dut_cout, dut_s} != gold_sum);
  assign last_vec = &v_q;
  assign stop_now = last_vec || (mismatch && (STOP_ON_ERR != 0));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_DRIVE;
      ST_DRIVE:  state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == '0) state_d = ST_CHECK;
      ST_CHECK:  state_d = stop_now ? ST_DONE : ST_DRIVE;
      ST_DONE:   if (start) state_d = ST_DRIVE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_DRIVE, ST_SETTLE, ST_CHECK: busy = 1'b1;
      ST_DONE:                       done = 1'b1;
      default: ;
    endcase
  end

  assign pass           = done && (err_q == '0);
  assign err_count      = err_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_vec = ffvec_q;
  assign dut_a          = a_q;
  assign dut_b          = b_q;
  assign dut_cin        = cin_q;

  // Datapath next values
  always_comb begin
    v_d     = v_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A new sweep clears results; dut_* keep the last vector until the next DRIVE.
        if (start) begin
          v_d     = '0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
        end
      end
      ST_DRIVE: begin
        a_d   = v_q[VW-1 -: WIDTH];
        b_d   = v_q[WIDTH -: WIDTH];
        cin_d = v_q[0];
        cnt_d = CW'(SETTLE - 1);
      end
      ST_SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = v_q;
          end
        end
        // The all-ones vector is terminal, so v never wraps.
        if (!stop_now) v_d = v_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
    end else begin
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
    end
  end

endmodule
